// File: rtl/alarm_sequencer_if.sv
// Request inputs and status outputs of the alarm sequencer.
// The master side drives requests and the slave side (the sequencer) drives status.
interface alarm_sequencer_if;
    logic       arm_req;
    logic       laser_break;
    logic       code_valid;
    logic       code_ok;
    logic [1:0] system_state;
    logic [7:0] seconds_left;
    logic       tick;
    logic       siren;
    logic       locked_out;
    logic [1:0] fail_count;

    modport master (
        output arm_req, laser_break, code_valid, code_ok,
        input  system_state, seconds_left, tick, siren, locked_out, fail_count
    );

    modport slave (
        input  arm_req, laser_break, code_valid, code_ok,
        output system_state, seconds_left, tick, siren, locked_out, fail_count
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Timed arming controller: exit/entry delays, bounded siren, passcode lockout.
// A private 1 Hz prescaler drives every countdown.
module alarm_sequencer #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned EXIT_DELAY   = 10,
    parameter int unsigned ENTRY_DELAY  = 15,
    parameter int unsigned SIREN_TIME   = 60,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned LOCKOUT_TIME = 30
) (
    input  logic             clock,
    input  logic             rst,
    alarm_sequencer_if.slave bus
);
    localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [7:0]    EXIT_SECS  = 8'(EXIT_DELAY);
    localparam logic [7:0]    ENTRY_SECS = 8'(ENTRY_DELAY);
    localparam logic [7:0]    SIREN_SECS = 8'(SIREN_TIME);
    localparam logic [7:0]    LOCK_SECS  = 8'(LOCKOUT_TIME);
    localparam logic [1:0]    FAIL_MAX   = 2'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXIT,
        S_ARMED,
        S_ENTRY,
        S_ALERT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    secs_q, secs_d;
    logic [7:0]    lock_q, lock_d;
    logic [1:0]    fail_q, fail_d;
    logic [1:0]    sys_q, sys_d;
    logic          tick_q, tick_d;
    logic          siren_q, siren_d;
    logic          locked_q, locked_d;
    logic          lock_now;
    logic          correct;
    logic          wrong;

    // Codes are only heard while not locked out.
    assign correct = bus.code_valid & bus.code_ok & ~locked_q;
    assign wrong   = bus.code_valid & ~bus.code_ok & ~locked_q;

    always_comb begin
        state_d  = state_q;
        secs_d   = secs_q;
        lock_d   = lock_q;
        fail_d   = fail_q;
        siren_d  = siren_q;
        locked_d = locked_q;
        lock_now = 1'b0;

        if (state_q != S_IDLE && correct) begin
            state_d = S_IDLE;
            secs_d  = 8'd0;
            siren_d = 1'b0;
            fail_d  = 2'd0;
        end else begin
            if (locked_q) begin
                if (tick_q) begin
                    if (lock_q == 8'd1) begin
                        locked_d = 1'b0;
                        fail_d   = 2'd0;
                        lock_d   = 8'd0;
                    end else if (lock_q != 8'd0) begin
                        lock_d = lock_q - 8'd1;
                    end
                end
            end else if (state_q != S_IDLE && wrong) begin
                if (fail_q >= FAIL_MAX - 2'd1) begin
                    fail_d   = FAIL_MAX;
                    locked_d = 1'b1;
                    lock_d   = LOCK_SECS;
                    lock_now = 1'b1;
                end else begin
                    fail_d = fail_q + 2'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.arm_req && !locked_q) begin
                        state_d = S_EXIT;
                        secs_d  = EXIT_SECS;
                    end
                end
                S_EXIT: begin
                    if (tick_q) begin
                        if (secs_q == 8'd1) begin
                            state_d = S_ARMED;
                            secs_d  = 8'd0;
                        end else if (secs_q != 8'd0) begin
                            secs_d = secs_q - 8'd1;
                        end
                    end
                end
                S_ARMED: begin
                    if (bus.laser_break) begin
                        state_d = S_ENTRY;
                        secs_d  = ENTRY_SECS;
                    end
                end
                S_ENTRY: begin
                    // Lockout during the entry window skips straight to the siren.
                    if (lock_now) begin
                        state_d = S_ALERT;
                        secs_d  = SIREN_SECS;
                        siren_d = 1'b1;
                    end else if (tick_q) begin
                        if (secs_q == 8'd1) begin
                            state_d = S_ALERT;
                            secs_d  = SIREN_SECS;
                            siren_d = 1'b1;
                        end else if (secs_q != 8'd0) begin
                            secs_d = secs_q - 8'd1;
                        end
                    end
                end
                S_ALERT: begin
                    if (tick_q) begin
                        if (secs_q == 8'd1) begin
                            state_d = S_ARMED;
                            secs_d  = 8'd0;
                            siren_d = 1'b0;
                        end else if (secs_q != 8'd0) begin
                            secs_d = secs_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    secs_d  = 8'd0;
                    siren_d = 1'b0;
                end
            endcase
        end
    end

    // Prescaler restarts on every state change so each phase gets whole seconds.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (state_d != state_q || presc_q == PRESC_MAX) begin
            presc_d = '0;
        end
        tick_d = (presc_d == PRESC_MAX);
    end

    always_comb begin
        sys_d = 2'b00;
        case (state_d)
            S_IDLE:  sys_d = 2'b00;
            S_EXIT:  sys_d = 2'b01;
            S_ARMED: sys_d = 2'b01;
            S_ENTRY: sys_d = 2'b10;
            S_ALERT: sys_d = 2'b11;
            default: sys_d = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            secs_q   <= 8'd0;
            lock_q   <= 8'd0;
            fail_q   <= 2'd0;
            sys_q    <= 2'b00;
            tick_q   <= 1'b0;
            siren_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            secs_q   <= secs_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
            sys_q    <= sys_d;
            tick_q   <= tick_d;
            siren_q  <= siren_d;
            locked_q <= locked_d;
        end
    end

    assign bus.system_state = sys_q;
    assign bus.seconds_left = secs_q;
    assign bus.tick         = tick_q;
    assign bus.siren        = siren_q;
    assign bus.locked_out   = locked_q;
    assign bus.fail_count   = fail_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed scenarios, then random traffic,
// all predicted by a seconds-level behavioural model.
module tb_alarm_sequencer;
    localparam int CLK_HZ       = 4;
    localparam int EXIT_DELAY   = 2;
    localparam int ENTRY_DELAY  = 3;
    localparam int SIREN_TIME   = 2;
    localparam int MAX_ATTEMPTS = 3;
    localparam int LOCKOUT_TIME = 2;

    localparam int M_IDLE  = 0;
    localparam int M_EXIT  = 1;
    localparam int M_ARMED = 2;
    localparam int M_ENTRY = 3;
    localparam int M_ALERT = 4;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] secs;
        logic       tick;
        logic       siren;
        logic       locked;
        logic [1:0] fails;
    } obs_t;

    logic clock = 1'b0;
    logic rst;
    alarm_sequencer_if bus();

    alarm_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .EXIT_DELAY  (EXIT_DELAY),
        .ENTRY_DELAY (ENTRY_DELAY),
        .SIREN_TIME  (SIREN_TIME),
        .MAX_ATTEMPTS(MAX_ATTEMPTS),
        .LOCKOUT_TIME(LOCKOUT_TIME)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Model: current phase, whole seconds remaining, and cycles since the phase began.
    int   m_mode, m_secs, m_lock, m_fails, m_since;
    bit   m_locked;
    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [1:0] enc(input int mode);
        if (mode == M_IDLE)  return 2'b00;
        if (mode == M_ENTRY) return 2'b10;
        if (mode == M_ALERT) return 2'b11;
        return 2'b01;
    endfunction

    function automatic obs_t mk(input logic [1:0] st, input int secs, input bit tk,
                                input bit sr, input bit lk, input int fails);
        obs_t o;
        o.st     = st;
        o.secs   = 8'(secs);
        o.tick   = tk;
        o.siren  = sr;
        o.locked = lk;
        o.fails  = 2'(fails);
        return o;
    endfunction

    function automatic bit model_tick_now();
        return (m_since % CLK_HZ) == CLK_HZ - 1;
    endfunction

    task automatic model_step(input bit a, input bit lb, input bit cv, input bit ok, input bit r);
        int prev;
        bit tk, good, bad, lock_started;
        tk           = model_tick_now();
        prev         = m_mode;
        good         = cv && ok && !m_locked;
        bad          = cv && !ok && !m_locked;
        lock_started = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_secs = 0; m_lock = 0; m_fails = 0; m_locked = 1'b0;
        end else if (m_mode != M_IDLE && good) begin
            m_mode = M_IDLE; m_secs = 0; m_fails = 0;
        end else begin
            if (m_locked && tk) begin
                m_lock = m_lock - 1;
                if (m_lock == 0) begin
                    m_locked = 1'b0;
                    m_fails  = 0;
                end
            end else if (m_mode != M_IDLE && bad) begin
                if (m_fails < MAX_ATTEMPTS) m_fails = m_fails + 1;
                if (m_fails == MAX_ATTEMPTS) begin
                    m_locked     = 1'b1;
                    m_lock       = LOCKOUT_TIME;
                    lock_started = 1'b1;
                end
            end
            if (m_mode == M_ENTRY && lock_started) begin
                m_mode = M_ALERT;
                m_secs = SIREN_TIME;
            end else if (tk && m_secs > 0 &&
                         (m_mode == M_EXIT || m_mode == M_ENTRY || m_mode == M_ALERT)) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    if (m_mode == M_ENTRY) begin
                        m_mode = M_ALERT;
                        m_secs = SIREN_TIME;
                    end else begin
                        m_mode = M_ARMED;
                    end
                end
            end else if (m_mode == M_ARMED && lb) begin
                m_mode = M_ENTRY;
                m_secs = ENTRY_DELAY;
            end else if (m_mode == M_IDLE && a && !m_locked) begin
                m_mode = M_EXIT;
                m_secs = EXIT_DELAY;
            end
        end
        if (r || m_mode != prev) m_since = 0;
        else m_since = m_since + 1;
    endtask

    // One clock of stimulus: drive on the falling edge, predict the next rising edge.
    task automatic cyc(input bit a, input bit lb, input bit cv, input bit ok, input bit r);
        @(negedge clock);
        bus.arm_req     = a;
        bus.laser_break = lb;
        bus.code_valid  = cv;
        bus.code_ok     = ok;
        rst             = r;
        model_step(a, lb, cv, ok, r);
        exp_q.push_back(mk(enc(m_mode), m_secs, model_tick_now(), m_mode == M_ALERT,
                           m_locked, m_fails));
    endtask

    task automatic spot(input string name, input obs_t want);
        obs_t got;
        @(posedge clock);
        #2;
        got = {bus.system_state, bus.seconds_left, bus.tick, bus.siren, bus.locked_out, bus.fail_count};
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got st=%0d secs=%0d tick=%0b siren=%0b lock=%0b fails=%0d, want st=%0d secs=%0d tick=%0b siren=%0b lock=%0b fails=%0d",
                     name, got.st, got.secs, got.tick, got.siren, got.locked, got.fails,
                     want.st, want.secs, want.tick, want.siren, want.locked, want.fails);
        end
    endtask

    // Monitor: every rising edge with a pending prediction is compared.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = {bus.system_state, bus.seconds_left, bus.tick, bus.siren, bus.locked_out, bus.fail_count};
                checks = checks + 1;
                if (g !== e) begin
                    errors = errors + 1;
                    $display("FAIL cycle t=%0t: got st=%0d secs=%0d tick=%0b siren=%0b lock=%0b fails=%0d, want st=%0d secs=%0d tick=%0b siren=%0b lock=%0b fails=%0d",
                             $time, g.st, g.secs, g.tick, g.siren, g.locked, g.fails,
                             e.st, e.secs, e.tick, e.siren, e.locked, e.fails);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit lb_lvl;
        bit a, cv, ok, r;
        bus.arm_req = 1'b0; bus.laser_break = 1'b0; bus.code_valid = 1'b0; bus.code_ok = 1'b0;
        rst = 1'b1;
        m_mode = M_IDLE; m_secs = 0; m_lock = 0; m_fails = 0; m_since = 0; m_locked = 1'b0;

        repeat (2) cyc(0, 0, 0, 0, 1);
        spot("reset", mk(2'b00, 0, 0, 0, 0, 0));

        // Arm flow
        cyc(1, 0, 0, 0, 0);
        spot("arm_exit", mk(2'b01, 2, 0, 0, 0, 0));
        repeat (4) cyc(0, 0, 0, 0, 0);
        spot("exit_count", mk(2'b01, 1, 0, 0, 0, 0));
        repeat (4) cyc(0, 0, 0, 0, 0);
        spot("armed", mk(2'b01, 0, 0, 0, 0, 0));

        // Trigger, alert, re-arm and immediate re-trigger
        cyc(0, 1, 0, 0, 0);
        spot("entry", mk(2'b10, 3, 0, 0, 0, 0));
        repeat (12) cyc(0, 1, 0, 0, 0);
        spot("alert", mk(2'b11, 2, 0, 1, 0, 0));
        repeat (8) cyc(0, 1, 0, 0, 0);
        spot("rearm", mk(2'b01, 0, 0, 0, 0, 0));
        cyc(0, 1, 0, 0, 0);
        spot("retrigger", mk(2'b10, 3, 0, 0, 0, 0));

        // Disarm exactly on the expiring tick
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == M_ENTRY && m_secs == 1 && model_tick_now()) found = 1'b1;
            else cyc(0, 0, 0, 0, 0);
        end
        checks = checks + 1;
        if (!found) begin
            errors = errors + 1;
            $display("FAIL disarm_wait: got no expiring entry tick within 40 cycles, want one");
        end
        cyc(0, 0, 1, 1, 0);
        spot("disarm_race", mk(2'b00, 0, 0, 0, 0, 0));

        // Lockout inside the entry window
        cyc(1, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        spot("lockout", mk(2'b11, 2, 0, 1, 1, 3));
        cyc(0, 0, 1, 1, 0);
        spot("locked_code_ignored", mk(2'b11, 2, 0, 1, 1, 3));
        repeat (7) cyc(0, 0, 0, 0, 0);
        spot("unlock", mk(2'b01, 0, 0, 0, 0, 0));

        // Codes and beam are ignored while idle
        cyc(0, 0, 1, 1, 0);
        repeat (3) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        spot("idle_immunity", mk(2'b00, 0, 0, 0, 0, 0));

        // Reset in the middle of an alert
        cyc(1, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        spot("reset_mid_alert", mk(2'b00, 0, 0, 0, 0, 0));

        // Random traffic; wrong codes are kept off tick cycles
        lb_lvl = 1'b0;
        repeat (3000) begin
            a  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) lb_lvl = ~lb_lvl;
            cv = ($urandom_range(0, 11) == 0);
            ok = ($urandom_range(0, 1) == 1);
            if (cv && !ok && model_tick_now()) cv = 1'b0;
            r  = ($urandom_range(0, 599) == 0);
            cyc(a, lb_lvl, cv, ok, r);
        end

        repeat (3) @(posedge clock);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Timed arming controller for the laser security system. It turns raw arm requests, laser-beam breaks and passcode verdicts into the 2-bit system state consumed by the display blocks (IDLE/SET/TRIGGER/ALERT). It applies exit and entry delays, bounds the siren duration, and locks out passcode entry after repeated wrong codes. It owns its own 1 Hz tick derived from the 50 MHz clock.

Parameters:
CLK_HZ, 50000000, clock cycles per second tick
EXIT_DELAY, 10, seconds from arm request to fully armed (1..255)
ENTRY_DELAY, 15, seconds from beam break to alert (1..255)
SIREN_TIME, 60, seconds the siren sounds before auto re-arm (1..255)
MAX_ATTEMPTS, 3, consecutive wrong codes that trigger lockout (1..3)
LOCKOUT_TIME, 30, lockout duration in seconds (1..255)

Ports:
clock  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
arm_req  in  1  one-cycle pulse requesting arming
laser_break  in  1  level; 1 = beam interrupted
code_valid  in  1  one-cycle pulse; a passcode entry has completed
code_ok  in  1  qualifies code_valid; 1 = code correct
system_state  out  2  00 IDLE, 01 SET, 10 TRIGGER, 11 ALERT
seconds_left  out  8  countdown for the current timed phase; 0 when untimed
tick  out  1  one-cycle 1 Hz strobe
siren  out  1  alarm output
locked_out  out  1  passcode lockout active
fail_count  out  2  consecutive wrong codes

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; all outputs 0; prescaler, lockout counter and fail_count cleared.
- Prescaler counts 0..CLK_HZ-1. tick=1 for the cycle in which the count equals CLK_HZ-1. The prescaler is forced to 0 on every state transition, so each timed phase gets full-length seconds.
- Internal states and system_state encoding: IDLE->00, EXIT->01, ARMED->01, ENTRY->10, ALERT->11.
- "Correct code" = code_valid & code_ok & !locked_out. "Wrong code" = code_valid & !code_ok & !locked_out.
- IDLE:
  - arm_req & !locked_out -> EXIT; seconds_left=EXIT_DELAY.
  - All codes ignored, including for fail counting.
- EXIT:
  - Each tick decrements seconds_left.
  - Tick with seconds_left==1 -> ARMED; seconds_left=0.
  - laser_break ignored.
- ARMED: laser_break=1 -> ENTRY; seconds_left=ENTRY_DELAY.
- ENTRY: tick with seconds_left==1 -> ALERT; seconds_left=SIREN_TIME.
- ALERT:
  - siren=1 (registered; asserted in the same cycle system_state shows 11).
  - Tick with seconds_left==1 -> ARMED, siren=0. If the beam is still broken, ENTRY follows on the next cycle.
- A correct code in EXIT, ARMED, ENTRY or ALERT -> IDLE. It clears seconds_left, siren and fail_count.
- A wrong code in any non-IDLE state increments fail_count. On reaching MAX_ATTEMPTS:
  - locked_out=1 and lock_left=LOCKOUT_TIME.
  - If in ENTRY, go to ALERT immediately; seconds_left=SIREN_TIME.
- During lockout:
  - Every tick decrements lock_left.
  - Tick with lock_left==1 clears locked_out and fail_count.
  - The state machine otherwise proceeds normally.
- Priority within one cycle: rst > correct code > wrong code > tick expiry > laser_break > arm_req.
  - A correct code beats a simultaneous expiry or beam break.
  - A wrong code causing lockout in ENTRY beats tick expiry; the result is ALERT with a fresh SIREN_TIME.
- arm_req outside IDLE is ignored. code_ok without code_valid is ignored.
- fail_count saturates at MAX_ATTEMPTS.
- seconds_left never wraps below 0.
- Mid-operation rst returns to IDLE from any state, including lockout, with the same values as power-up reset.

Test Plan:
Use CLK_HZ=4 and EXIT_DELAY=2, ENTRY_DELAY=3, SIREN_TIME=2, MAX_ATTEMPTS=3, LOCKOUT_TIME=2 for all scenarios.
- Arm flow: arm_req pulse -> system_state=01 and seconds_left=2 next cycle; 1 after 4 cycles; ARMED with seconds_left=0 after 8 cycles.
- Trigger/alert/re-arm: in ARMED, hold laser_break=1 -> state 10, seconds_left=3; after 12 cycles state 11, siren=1, seconds_left=2; after 8 more cycles state 01, siren=0, then 10 on the next cycle.
- Disarm race: in ENTRY with seconds_left=1, assert code_valid=1, code_ok=1 on the tick cycle -> IDLE, siren stays 0, fail_count=0.
- Lockout: in ENTRY, three wrong codes -> fail_count 1, 2, 3. On the third: locked_out=1 and state 11 immediately. A correct code during lockout -> ignored, state stays 11. After 8 cycles locked_out=0 and fail_count=0.
- IDLE immunity: in IDLE, issue wrong codes and laser_break=1 -> state stays 00, fail_count stays 0. arm_req during lockout -> stays 00.
- Reset mid-ALERT: rst for 1 cycle -> next cycle state 00, siren=0, seconds_left=0, locked_out=0, tick=0.
